instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_INC, default 4: byte increment applied to the PC per issued fetch.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc_cur  input  64  current PC, driven by the PC register output.
REQ-005 pc_next  output  64  next PC, driving the PC register input; loaded by that register every clk.
REQ-006 imem_req  output  1  instruction memory request valid.
REQ-007 imem_addr  output  64  request address.
REQ-008 imem_gnt  input  1  request accepted this cycle; meaningful only while imem_req=1.
REQ-009 imem_rvalid  input  1  response data valid, at least one cycle after the grant.
REQ-010 imem_rdata  input  32  response instruction word.
REQ-011 redirect  input  1  branch/exception redirect request.
REQ-012 redirect_pc  input  64  redirect target address.
REQ-013 id_ready  input  1  decode stage accepts the IF/ID entry this cycle.
REQ-014 id_valid  output  1  IF/ID entry valid.
REQ-015 id_instr  output  32  IF/ID instruction.
REQ-016 id_pc  output  64  address of id_instr.
REQ-017 stall_cnt  output  32  count of decode back-pressure cycles.

Function
REQ-018 The FSM SHALL have states FETCH, WAIT, HOLD and DRAIN, with at most one memory request outstanding.
REQ-019 imem_req SHALL be asserted only when state=FETCH, redirect=0 and reset=0; imem_addr SHALL equal pc_cur at all times.
REQ-020 In FETCH, imem_req=1 and imem_gnt=1 SHALL capture pc_cur into req_pc, set pc_next=pc_cur+PC_INC (mod 2^64), and move to WAIT.
REQ-021 In every other cycle without redirect, pc_next SHALL equal pc_cur.
REQ-022 In WAIT with imem_rvalid=1 and the IF/ID slot free (id_valid=0 or id_ready=1), imem_rdata/req_pc SHALL load id_instr/id_pc, set id_valid=1 and move to FETCH.
REQ-023 In WAIT with imem_rvalid=1 and the slot occupied (id_valid=1, id_ready=0), the response SHALL load a one-entry skid buffer and the FSM SHALL move to HOLD.
REQ-024 In HOLD with id_ready=1, the skid buffer SHALL move into IF/ID (id_valid stays 1) and the FSM SHALL move to FETCH.
REQ-025 id_ready=1 with no new load SHALL clear id_valid on the next edge.
REQ-026 redirect=1 SHALL take priority over all other events: pc_next=redirect_pc; id_valid and the skid buffer cleared on the next edge.
REQ-027 redirect in WAIT with imem_rvalid=0 SHALL move to DRAIN; in DRAIN the next imem_rvalid SHALL be discarded and the FSM SHALL move to FETCH.
REQ-028 redirect in WAIT with imem_rvalid=1 in the same cycle SHALL discard the response and move to FETCH.
REQ-029 redirect in FETCH or HOLD SHALL move to FETCH; redirect in DRAIN SHALL stay in DRAIN.
REQ-030 imem_rvalid outside WAIT and DRAIN SHALL be ignored.

Reset
REQ-031 reset SHALL asynchronously force state=FETCH, id_valid=0, id_instr=0, id_pc=0, req_pc=0, skid empty and stall_cnt=0.
REQ-032 While reset=1, imem_req SHALL be 0 and pc_next SHALL equal pc_cur.
REQ-033 Reset asserted mid-transaction SHALL abandon the outstanding request; no late response may reach IF/ID after reset deasserts.

Configuration
REQ-034 With macro FETCH_STALL_CNT_EN defined, stall_cnt SHALL increment each cycle id_valid=1 and id_ready=0, saturating at 32'hFFFFFFFF.
REQ-035 Without FETCH_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-036 Reset, pc_cur=0, imem_gnt=1 immediately, rvalid one cycle later with 32'h8B020020, id_ready=1 -> pc_next=4; id_valid=1, id_instr=8B020020, id_pc=0.
REQ-037 IF/ID full with id_ready=0, response 32'hAAAA0001 arrives -> HOLD; then id_ready=1 for one cycle -> id_instr=AAAA0001, id_valid=1; FSM in FETCH.
REQ-038 Redirect to 64'h100 in WAIT, rvalid two cycles later -> DRAIN; response discarded; next request has imem_addr=100.
REQ-039 Redirect and rvalid in the same WAIT cycle -> id_valid=0 next cycle; FSM in FETCH; pc_next=redirect_pc in that cycle.
REQ-040 pc_cur=64'hFFFFFFFFFFFFFFFC granted -> pc_next=0.
REQ-041 With FETCH_STALL_CNT_EN, hold id_valid=1, id_ready=0 for 5 cycles -> stall_cnt=5; reset -> 0; without the macro -> 0 throughout.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: one outstanding request, IF/ID register with skid buffer.
// Optional decode back-pressure counter enabled by defining FETCH_STALL_CNT_EN.
module instr_fetch #(
  parameter int unsigned PC_INC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_cur,
  output logic [63:0] pc_next,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [63:0] req_pc, req_pc_d;
  logic        id_valid_d;
  logic [31:0] id_instr_d;
  logic [63:0] id_pc_d;
  logic        skid_valid, skid_valid_d;
  logic [31:0] skid_instr, skid_instr_d;
  logic [63:0] skid_pc, skid_pc_d;
  logic        slot_free;

  assign imem_addr = pc_cur;
  assign slot_free = !id_valid || id_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      req_pc     <= '0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state      <= state_d;
      req_pc     <= req_pc_d;
      id_valid   <= id_valid_d;
      id_instr   <= id_instr_d;
      id_pc      <= id_pc_d;
      skid_valid <= skid_valid_d;
      skid_instr <= skid_instr_d;
      skid_pc    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state;
    req_pc_d     = req_pc;
    id_valid_d   = id_ready ? 1'b0 : id_valid;
    id_instr_d   = id_instr;
    id_pc_d      = id_pc;
    skid_valid_d = skid_valid;
    skid_instr_d = skid_instr;
    skid_pc_d    = skid_pc;
    pc_next      = pc_cur;
    imem_req     = (state == FETCH) && !redirect && !reset;

    case (state)
      FETCH: begin
        if (imem_req && imem_gnt) begin
          req_pc_d = pc_cur;
          pc_next  = pc_cur + 64'(PC_INC);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (slot_free) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = req_pc;
            state_d    = FETCH;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_pc;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (id_ready) begin
          id_valid_d   = 1'b1;
          id_instr_d   = skid_instr;
          id_pc_d      = skid_pc;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // A redirect flushes everything; a request still in flight must be drained first.
    if (redirect) begin
      pc_next      = redirect_pc;
      id_valid_d   = 1'b0;
      id_instr_d   = id_instr;
      id_pc_d      = id_pc;
      skid_valid_d = 1'b0;
      if ((state == WAIT || state == DRAIN) && !imem_rvalid) state_d = DRAIN;
      else                                                  state_d = FETCH;
    end

    if (reset) pc_next = pc_cur;
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                stall_cnt_q <= '0;
    else if (id_valid && !id_ready && stall_cnt_q != '1)      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
